// File: rtl/usb_out_pkg.sv
// Shared types for the USB OUT transaction generator: failure causes, FSM states
// and the bundle of registered transaction outputs.
package usb_out_pkg;

    typedef enum logic [1:0] {
        FAIL_NONE    = 2'd0,
        FAIL_TIMEOUT = 2'd1,
        FAIL_NAK     = 2'd2,
        FAIL_STALL   = 2'd3
    } fail_code_t;

    typedef enum logic [1:0] {
        StIdle         = 2'd0,
        StWaitSendOut  = 2'd1,
        StWaitSendData = 2'd2,
        StWaitResponse = 2'd3
    } out_state_t;

    // Everything the FSM drives towards the outside world, registered as one word.
    typedef struct packed {
        logic       sending;
        logic       done;
        logic       success;
        logic       failure;
        fail_code_t fail_code;
        logic       send_out;
        logic       send_data;
        logic       data_pid1;
    } out_ctrl_t;

endpackage

// File: rtl/out_retry_cnt.sv
// Bounded retry counter: counts retries up to Limit-1 and flags when the next
// failure of the same kind must end the transaction.
module out_retry_cnt #(
    parameter int unsigned CntW  = 16,
    parameter int unsigned Limit = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam logic [CntW-1:0] LastVal = CntW'(Limit - 1);

    logic [CntW-1:0] count_q;

    assign at_limit = (count_q == LastVal);

    // Saturates at the limit value so the count can never wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !at_limit) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/out_trans_gen.sv
// USB OUT transaction generator: OUT token, DATA packet, then handshake wait with
// NAK/timeout retries. Define OUT_TRANS_TOGGLE_EN to enable the DATA0/DATA1 toggle.
module out_trans_gen
    import usb_out_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_TIMEOUTS   = 8,
    parameter int unsigned MAX_NAKS       = 8,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       sending,
    output logic       done,
    output logic       success,
    output logic       failure,
    output fail_code_t fail_code,
    input  logic       sent,
    output logic       send_OUT,
    output logic       send_DATA,
    output logic       data_pid1,
    input  logic       rec_ACK,
    input  logic       rec_NAK,
    input  logic       rec_STALL,
    input  logic       rec_start,
    input  logic       toggle_clr
);

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    out_state_t       state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    out_ctrl_t        ctrl_q, ctrl_d;

    logic in_resp;
    logic ev_ack, ev_stall, ev_nak, ev_to;
    logic nak_at_limit, to_at_limit;
    logic cnt_clr, nak_inc, to_inc;
    logic retry, txn_end;
    logic toggle;

    // Response decode in priority order: rec_start masks everything below it.
    assign in_resp  = (state_q == StWaitResponse);
    assign ev_ack   = in_resp & ~rec_start & rec_ACK;
    assign ev_stall = in_resp & ~rec_start & ~rec_ACK & rec_STALL;
    assign ev_nak   = in_resp & ~rec_start & ~rec_ACK & ~rec_STALL & rec_NAK;
    assign ev_to    = in_resp & ~rec_start & ~rec_ACK & ~rec_STALL & ~rec_NAK &
                      (cyc_q == TimeoutLast);

    assign nak_inc = ev_nak & ~nak_at_limit;
    assign to_inc  = ev_to & ~to_at_limit;
    assign retry   = nak_inc | to_inc;
    assign txn_end = ev_ack | ev_stall | (ev_nak & nak_at_limit) | (ev_to & to_at_limit);
    assign cnt_clr = (state_q == StWaitSendOut) & sent;

    out_retry_cnt #(
        .CntW (CNT_W),
        .Limit(MAX_NAKS)
    ) u_nak_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr     (cnt_clr),
        .inc     (nak_inc),
        .at_limit(nak_at_limit)
    );

    out_retry_cnt #(
        .CntW (CNT_W),
        .Limit(MAX_TIMEOUTS)
    ) u_to_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr     (cnt_clr),
        .inc     (to_inc),
        .at_limit(to_at_limit)
    );

`ifdef OUT_TRANS_TOGGLE_EN
    logic toggle_q, toggle_d;

    // toggle_clr takes precedence over an ACK flip in the same cycle.
    always_comb begin
        toggle_d = toggle_q;
        if (toggle_clr) begin
            toggle_d = 1'b0;
        end else if (ev_ack) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign toggle = toggle_q;
`else
    logic unused_toggle_clr;

    assign unused_toggle_clr = toggle_clr;
    assign toggle            = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StWaitSendOut;
            end
            StWaitSendOut: begin
                if (sent) state_d = StWaitSendData;
            end
            StWaitSendData: begin
                if (sent) begin
                    state_d = StWaitResponse;
                    cyc_d   = '0;
                end
            end
            StWaitResponse: begin
                cyc_d = rec_start ? '0 : cyc_q + 1'b1;
                if (txn_end) begin
                    state_d = start ? StWaitSendOut : StIdle;
                end else if (retry) begin
                    state_d = StWaitSendData;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ctrl_d           = '0;
        ctrl_d.fail_code = ctrl_q.fail_code;
        case (state_q)
            StIdle: begin
                ctrl_d.send_out = start;
            end
            StWaitSendOut: begin
                if (sent) begin
                    ctrl_d.send_data = 1'b1;
                    ctrl_d.data_pid1 = toggle;
                end else begin
                    ctrl_d.sending = 1'b1;
                end
            end
            StWaitSendData: begin
                ctrl_d.sending = ~sent;
            end
            StWaitResponse: begin
                if (txn_end) begin
                    ctrl_d.done     = 1'b1;
                    ctrl_d.success  = ev_ack;
                    ctrl_d.failure  = ~ev_ack;
                    ctrl_d.send_out = start;
                    if (ev_stall) begin
                        ctrl_d.fail_code = FAIL_STALL;
                    end else if (ev_nak) begin
                        ctrl_d.fail_code = FAIL_NAK;
                    end else if (ev_to) begin
                        ctrl_d.fail_code = FAIL_TIMEOUT;
                    end else begin
                        ctrl_d.fail_code = FAIL_NONE;
                    end
                end else if (retry) begin
                    // Retries resend with the unchanged toggle, so the PID is repeated.
                    ctrl_d.send_data = 1'b1;
                    ctrl_d.data_pid1 = toggle;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign sending   = ctrl_q.sending;
    assign done      = ctrl_q.done;
    assign success   = ctrl_q.success;
    assign failure   = ctrl_q.failure;
    assign fail_code = ctrl_q.fail_code;
    assign send_OUT  = ctrl_q.send_out;
    assign send_DATA = ctrl_q.send_data;
    assign data_pid1 = ctrl_q.data_pid1;

endmodule

// File: tb/tb_out_trans_gen.sv
// Directed self-checking bench for out_trans_gen (default parameters).
module tb_out_trans_gen;
    import usb_out_pkg::*;

`ifdef OUT_TRANS_TOGGLE_EN
    localparam bit TogEn = 1'b1;
`else
    localparam bit TogEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic sent = 1'b0;
    logic rec_ACK = 1'b0;
    logic rec_NAK = 1'b0;
    logic rec_STALL = 1'b0;
    logic rec_start = 1'b0;
    logic toggle_clr = 1'b0;

    logic       sending, done, success, failure;
    logic       send_OUT, send_DATA, data_pid1;
    fail_code_t fail_code;

    int n_tests = 0;
    int n_fail  = 0;
    int sd_cnt  = 0;
    int done_cnt = 0;
    bit tog     = 1'b0;

    out_trans_gen dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .sending   (sending),
        .done      (done),
        .success   (success),
        .failure   (failure),
        .fail_code (fail_code),
        .sent      (sent),
        .send_OUT  (send_OUT),
        .send_DATA (send_DATA),
        .data_pid1 (data_pid1),
        .rec_ACK   (rec_ACK),
        .rec_NAK   (rec_NAK),
        .rec_STALL (rec_STALL),
        .rec_start (rec_start),
        .toggle_clr(toggle_clr)
    );

    initial forever #5 clock = ~clock;

    always @(negedge clock) begin
        if (send_DATA === 1'b1) sd_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_pid();
        return TogEn ? tog : 1'b0;
    endfunction

    function automatic logic [6:0] outs();
        return {sending, done, success, failure, send_OUT, send_DATA, data_pid1};
    endfunction

    task automatic begin_txn(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "/send_OUT"}, send_OUT, 1);
    endtask

    // In WAIT_SEND_OUT: sender busy for `waits` cycles, then the DATA request appears.
    task automatic out_phase(input string tag, input int waits);
        repeat (waits) tick();
        chk({tag, "/sending_out"}, sending, 1);
        sent = 1'b1;
        tick();
        sent = 1'b0;
        chk({tag, "/send_DATA"}, send_DATA, 1);
        chk({tag, "/pid"}, data_pid1, exp_pid());
    endtask

    task automatic data_phase(input string tag, input int waits);
        repeat (waits) tick();
        if (waits > 0) chk({tag, "/sending_data"}, sending, 1);
        sent = 1'b1;
        tick();
        sent = 1'b0;
        chk({tag, "/idle_wait"}, {sending, send_DATA, done}, 0);
    endtask

    task automatic ack(input string tag);
        rec_ACK = 1'b1;
        tick();
        rec_ACK = 1'b0;
        chk({tag, "/ack_done"}, {done, success, failure}, 3'b110);
        chk({tag, "/ack_code"}, fail_code, FAIL_NONE);
        tog = ~tog;
        tick();
        chk({tag, "/done_pulse"}, done, 0);
    endtask

    initial begin
        int s0;
        int d0;
        int resends;

        // Reset state
        repeat (2) tick();
        chk("rst/outs", outs(), 0);
        chk("rst/code", fail_code, FAIL_NONE);
        reset = 1'b0;
        tick();
        chk("rst/quiet", outs(), 0);

        // T1: basic ACKed transaction, DATA0
        begin_txn("t1");
        out_phase("t1", 3);
        data_phase("t1", 3);
        repeat (10) tick();
        chk("t1/no_early_done", done, 0);
        ack("t1");

        // T2: eight NAKs -> seven same-PID resends then FAIL_NAK
        begin_txn("t2");
        out_phase("t2", 3);
        data_phase("t2", 1);
        resends = 0;
        for (int i = 0; i < 8; i++) begin
            rec_NAK = 1'b1;
            tick();
            rec_NAK = 1'b0;
            if (i < 7) begin
                chk("t2/nak_no_done", done, 0);
                chk("t2/nak_pid", data_pid1, exp_pid());
                resends += int'(send_DATA);
                data_phase("t2r", 1);
            end else begin
                chk("t2/nak_fail", {done, success, failure}, 3'b101);
                chk("t2/nak_code", fail_code, FAIL_NAK);
            end
        end
        chk("t2/resends", resends, 7);
        tick();
        chk("t2/code_held", {done, fail_code}, {1'b0, FAIL_NAK});

        // T3: no response -> retry every 255 cycles, eighth timeout fails
        begin_txn("t3");
        out_phase("t3", 3);
        for (int i = 0; i < 8; i++) begin
            sent = 1'b1;
            tick();
            sent = 1'b0;
            s0 = sd_cnt;
            repeat (254) tick();
            chk("t3/no_early_retry", {sd_cnt - s0, 31'(done)}, 0);
            tick();
            if (i < 7) begin
                chk("t3/retry", send_DATA, 1);
                chk("t3/retry_pid", data_pid1, exp_pid());
            end else begin
                chk("t3/to_fail", {done, success, failure, send_DATA}, 4'b1010);
                chk("t3/to_code", fail_code, FAIL_TIMEOUT);
            end
        end
        tick();

        // T4: rec_start every 100 cycles keeps the timeout from firing
        begin_txn("t4");
        out_phase("t4", 3);
        data_phase("t4", 1);
        s0 = sd_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            repeat (99) tick();
            rec_start = 1'b1;
            tick();
            rec_start = 1'b0;
        end
        rec_start = 1'b1;
        rec_ACK = 1'b1;
        tick();
        rec_start = 1'b0;
        rec_ACK = 1'b0;
        chk("t4/rec_start_prio", done, 0);
        chk("t4/keepalive", {sd_cnt - s0, done_cnt - d0}, 0);
        ack("t4");

        // T5: STALL with start held -> failure and send_OUT in the done cycle
        begin_txn("t5");
        out_phase("t5", 3);
        data_phase("t5", 2);
        rec_STALL = 1'b1;
        start = 1'b1;
        tick();
        rec_STALL = 1'b0;
        start = 1'b0;
        chk("t5/stall", {done, success, failure, send_OUT}, 4'b1011);
        chk("t5/stall_code", fail_code, FAIL_STALL);

        // T6: back-to-back transaction, toggle unchanged by STALL; toggle_clr beats ACK
        tick();
        chk("t6/sending", {sending, send_OUT}, 2'b10);
        chk("t6/code_held", fail_code, FAIL_STALL);
        out_phase("t6", 1);
        data_phase("t6", 1);
        rec_ACK = 1'b1;
        toggle_clr = 1'b1;
        tick();
        rec_ACK = 1'b0;
        toggle_clr = 1'b0;
        chk("t6/ack", {done, success}, 2'b11);
        tog = 1'b0;
        tick();

        // T7: PID back to DATA0; start ignored while busy
        begin_txn("t7");
        out_phase("t7", 2);
        data_phase("t7", 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t7/start_ignored", {send_OUT, done}, 0);
        ack("t7");

        // T8: reset in WAIT_RESPONSE aborts without done and clears the toggle
        begin_txn("t8");
        out_phase("t8", 2);
        data_phase("t8", 1);
        repeat (5) tick();
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("t8/async_rst", outs(), 0);
        tick();
        rec_ACK = 1'b1;
        tick();
        chk("t8/rst_outs", {outs(), fail_code}, {7'b0, FAIL_NONE});
        reset = 1'b0;
        tick();
        rec_ACK = 1'b0;
        tick();
        chk("t8/no_done", done_cnt - d0, 0);
        tog = 1'b0;

        // T9: first transaction after reset uses DATA0
        begin_txn("t9");
        out_phase("t9", 3);
        data_phase("t9", 3);
        ack("t9");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
